pixel_readout_rx: RTL and testbench
===================================

Name: pixel_readout_rx

Overview:
- Receiving end of the PIXELTOP 8-bit readout bus.
- Samples DATA when the readout strobe is high and tags each sample with its row and column.
- Buffers samples in a small FIFO and presents them to downstream logic over a valid/ready handshake.
- Frames the stream by FRAME_START, pixel count and FRAME_DONE; sits between PIXELTOP and the image store/debug port.

Parameters:
- ROWS, 2, pixel rows per frame (≥1)
- COLS, 2, pixel columns per frame (≥1)
- FIFO_DEPTH, 4, sample buffer entries (power of two, ≥2)

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- DATA  in  8  pixel bus from PIXELTOP; valid only when READ_STB=1
- READ_STB  in  1  one-cycle qualifier: DATA holds a pixel this cycle
- FRAME_START  in  1  one-cycle pulse: readout of a new frame begins
- PIX_DATA  out  8  head-of-FIFO pixel value
- PIX_ROW  out  RW=max(1,$clog2(ROWS))  row tag of PIX_DATA
- PIX_COL  out  CW=max(1,$clog2(COLS))  column tag of PIX_DATA
- PIX_VALID  out  1  head entry present
- PIX_READY  in  1  consumer accepts when PIX_VALID&PIX_READY
- FRAME_DONE  out  1  one-cycle pulse: last pixel of frame accepted
- OVERFLOW  out  1  sticky: a strobed sample was dropped on FIFO full
- FRAME_ERR  out  1  one-cycle pulse: FRAME_START arrived mid-frame

Behaviour:
- Reset (async assert, sync release): state IDLE; counters, FIFO pointers and all outputs 0.
- State IDLE:
  - READ_STB ignored.
  - FRAME_START -> CAPTURE; row/col=0; OVERFLOW cleared.
- State CAPTURE:
  - On each READ_STB, push {DATA,row,col} and advance col.
  - col wraps at COLS-1 -> 0 and row++.
  - After the ROWS*COLS-th strobe -> DRAIN.
  - A dropped sample still advances the counters.
- State DRAIN:
  - READ_STB ignored.
  - When the pop of the final frame pixel is accepted: FRAME_DONE=1 that cycle (registered, visible the next cycle), then -> IDLE.
- FRAME_START in CAPTURE or DRAIN:
  - FRAME_ERR pulses.
  - FIFO flushed; that cycle's READ_STB is discarded.
  - Counters zeroed; state CAPTURE.
  - FRAME_DONE for the aborted frame is never issued.
- FIFO:
  - Registered head; latency from strobe edge to PIX_VALID is 1 cycle when empty.
  - PIX_DATA/ROW/COL hold stable while PIX_VALID&!PIX_READY.
  - Simultaneous push and pop when full: pop frees the slot, push accepted, no overflow.
  - Push when full without pop: sample dropped, OVERFLOW=1 until the next FRAME_START or RESET.
  - Pop when empty: no effect.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits with wrap bit.
- Last-pixel tracking: an accepted-pop counter (width $clog2(ROWS*COLS+1)) reaches ROWS*COLS -> FRAME_DONE. Dropped samples count as accepted so the frame still terminates.

Optional Feature:
- Macro PIXEL_RX_FRAME_SUM_EN.
- Defined: extra output FRAME_SUM, width 8+$clog2(ROWS*COLS+1).
  - Accumulates DATA of every successfully pushed sample in the frame.
  - Zeroed at FRAME_START.
  - Captured into FRAME_SUM in the same cycle FRAME_DONE is registered; holds until the next FRAME_DONE.
  - Reset value 0.
- Undefined: port and accumulator absent; all else identical.

Decomposition:
- Package pixel_rx_pkg:
  - state enum rx_state_t {IDLE, CAPTURE, DRAIN}
  - PIX_W=8 localparam
  - entry struct typedef (data, row, col), parameterised widths via the module
- Sub-module pixel_rx_fifo: sync FIFO with push/pop/full/empty/flush, generic width/depth. FSM and counters stay in the top.

Test Plan:
- Normal frame: ROWS=COLS=2, PIX_READY=1, FRAME_START then strobes with DATA 10,20,30,40 -> outputs (10,0,0),(20,0,1),(30,1,0),(40,1,1), each 1 cycle after its strobe; FRAME_DONE one pulse after 40 accepted; OVERFLOW=0; FRAME_SUM=100 if enabled.
- Backpressure: PIX_READY=0 during 4 strobes (depth 4) -> no overflow, PIX_DATA=10 held stable. Then READY=1 -> 4 pops in order, FRAME_DONE after the 4th.
- Overflow: FIFO_DEPTH=2, READY=0, 4 strobes 1,2,3,4 -> OVERFLOW=1 after the 3rd strobe; outputs 1,2 only; FRAME_DONE still fires after both pop; FRAME_SUM=3.
- Mid-frame restart: FRAME_START after 2 strobes -> FRAME_ERR pulse, FIFO empty next cycle, next 4 strobes tagged (0,0)..(1,1), no FRAME_DONE for the aborted frame.
- Async reset mid-CAPTURE with 2 entries queued -> PIX_VALID, OVERFLOW, FRAME_DONE =0 immediately, without a clock edge; strobes before the next FRAME_START are ignored.
- Full-boundary simultaneity: FIFO full, push and pop in the same cycle -> entry accepted, OVERFLOW stays 0, count unchanged.

Source files
------------

// File: rtl/pixel_rx_pkg.sv
// pixel_rx_pkg: shared types and helpers for the PIXELTOP readout receiver.
package pixel_rx_pkg;
    localparam int PIX_W = 8;
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} rx_state_t;
    // tag widths never collapse to zero, even for single-row or single-column frames
    function automatic int tag_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pixel_rx_fifo.sv
// pixel_rx_fifo: synchronous FIFO with flush; pop frees a full slot for a same-cycle push.
module pixel_rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]  wp_q, rp_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         wr, rd;
    assign empty_o = wp_q == rp_q;
    assign full_o  = wp_q[AW] != rp_q[AW] && wp_q[AW-1:0] == rp_q[AW-1:0];
    assign rd      = pop_i && !empty_o;
    assign wr      = push_i && (!full_o || rd);
    assign rdata_o = mem_q[rp_q[AW-1:0]];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q <= '0;
            rp_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (wr) begin
                mem_q[wp_q[AW-1:0]] <= wdata_i;
                wp_q <= wp_q + (AW + 1)'(1);
            end
            if (rd) rp_q <= rp_q + (AW + 1)'(1);
        end
    end
endmodule

// File: rtl/pixel_readout_rx.sv
// pixel_readout_rx: PIXELTOP readout receiver with row/col tagging, FIFO and frame tracking.
// Define PIXEL_RX_FRAME_SUM_EN to add the FRAME_SUM per-frame pixel accumulator output.
module pixel_readout_rx
    import pixel_rx_pkg::*;
#(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [PIX_W-1:0]        DATA,
    input  logic                    READ_STB,
    input  logic                    FRAME_START,
    output logic [PIX_W-1:0]        PIX_DATA,
    output logic [tag_w(ROWS)-1:0]  PIX_ROW,
    output logic [tag_w(COLS)-1:0]  PIX_COL,
    output logic                    PIX_VALID,
    input  logic                    PIX_READY,
    output logic                    FRAME_DONE,
    output logic                    OVERFLOW,
`ifdef PIXEL_RX_FRAME_SUM_EN
    output logic [PIX_W+$clog2(ROWS*COLS+1)-1:0] FRAME_SUM,
`endif
    output logic                    FRAME_ERR
);
    localparam int N  = ROWS * COLS;
    localparam int RW = tag_w(ROWS);
    localparam int CW = tag_w(COLS);
    localparam int PW = $clog2(N + 1);

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic [RW-1:0]    row;
        logic [CW-1:0]    col;
    } entry_t;

    rx_state_t     state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, done_q, done_d, err_q, err_d;
    logic          strobe, pop, full, empty, drop, push_ok, flush, count, col_wrap;
    entry_t        wr_e, rd_e;

    assign pop      = !empty && PIX_READY;
    assign strobe   = READ_STB && !FRAME_START && state_q == CAPTURE;
    assign drop     = strobe && full && !pop;
    assign push_ok  = strobe && !drop;
    assign flush    = FRAME_START && state_q != IDLE;
    // a dropped sample counts as delivered so a lossy frame still terminates
    assign count    = state_q != IDLE && !FRAME_START && (pop || drop);
    assign col_wrap = col_q == CW'(COLS - 1);
    assign wr_e     = '{data: DATA, row: row_q, col: col_q};

    pixel_rx_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .flush_i (flush),
        .push_i  (strobe),
        .pop_i   (pop),
        .wdata_i (wr_e),
        .rdata_o (rd_e),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = count ? cnt_q + PW'(1) : cnt_q;
        ovf_d   = ovf_q || drop;
        err_d   = flush;
        done_d  = count && cnt_q == PW'(N - 1);
        if (FRAME_START) begin
            state_d = CAPTURE;
            row_d   = '0;
            col_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (done_d) begin
            state_d = IDLE;
        end else if (strobe) begin
            col_d = col_wrap ? '0 : col_q + CW'(1);
            row_d = col_wrap ? row_q + RW'(1) : row_q;
            if (col_wrap && row_q == RW'(ROWS - 1)) state_d = DRAIN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef PIXEL_RX_FRAME_SUM_EN
    localparam int SW = PIX_W + PW;
    logic [SW-1:0] sum_q, sum_d, fsum_q;
    assign sum_d = FRAME_START ? '0 : sum_q + (push_ok ? SW'(DATA) : '0);
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sum_q  <= '0;
            fsum_q <= '0;
        end else begin
            sum_q <= sum_d;
            if (done_d) fsum_q <= sum_d;
        end
    end
    assign FRAME_SUM = fsum_q;
`else
    logic unused_push_ok;
    assign unused_push_ok = push_ok;
`endif

    assign PIX_DATA   = rd_e.data;
    assign PIX_ROW    = rd_e.row;
    assign PIX_COL    = rd_e.col;
    assign PIX_VALID  = !empty;
    assign FRAME_DONE = done_q;
    assign OVERFLOW   = ovf_q;
    assign FRAME_ERR  = err_q;
endmodule

// File: tb/tb_pixel_readout_rx.sv
// tb_pixel_readout_rx: two receivers (FIFO depth 4 and 2) on shared inputs, checked against a queue model.
module tb_pixel_readout_rx;
    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int N    = ROWS * COLS;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] DATA = '0;
    logic       READ_STB = 1'b0;
    logic       FRAME_START = 1'b0;
    logic       PIX_READY = 1'b0;

    logic [7:0] pd [2];
    logic       pr [2];
    logic       pc [2];
    logic       pv [2];
    logic       fd [2];
    logic       ov [2];
    logic       fe [2];
`ifdef PIXEL_RX_FRAME_SUM_EN
    logic [10:0] fs [2];
`endif

    int n_vec = 0;
    int n_err = 0;

    int mq [2][$];
    int dep [2] = '{4, 2};
    int act [2], seen [2], acc [2], movf [2], mdone [2], merr [2], msum [2], mfsum [2];

    always #5 CLK = ~CLK;

    pixel_readout_rx #(.ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(4)) u0 (
        .CLK(CLK), .RESET(RESET), .DATA(DATA), .READ_STB(READ_STB), .FRAME_START(FRAME_START),
        .PIX_DATA(pd[0]), .PIX_ROW(pr[0]), .PIX_COL(pc[0]), .PIX_VALID(pv[0]), .PIX_READY(PIX_READY),
        .FRAME_DONE(fd[0]), .OVERFLOW(ov[0]),
`ifdef PIXEL_RX_FRAME_SUM_EN
        .FRAME_SUM(fs[0]),
`endif
        .FRAME_ERR(fe[0])
    );

    pixel_readout_rx #(.ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(2)) u1 (
        .CLK(CLK), .RESET(RESET), .DATA(DATA), .READ_STB(READ_STB), .FRAME_START(FRAME_START),
        .PIX_DATA(pd[1]), .PIX_ROW(pr[1]), .PIX_COL(pc[1]), .PIX_VALID(pv[1]), .PIX_READY(PIX_READY),
        .FRAME_DONE(fd[1]), .OVERFLOW(ov[1]),
`ifdef PIXEL_RX_FRAME_SUM_EN
        .FRAME_SUM(fs[1]),
`endif
        .FRAME_ERR(fe[1])
    );

    function automatic int enc(input int d, input int r, input int c);
        return (d << 8) | (r << 4) | c;
    endfunction

    function automatic int head(input int i);
        return enc(int'(pd[i]), int'(pr[i]), int'(pc[i]));
    endfunction

    function automatic void chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endfunction

    // Reference: a plain queue per receiver; tags are the strobe index split by COLS.
    always @(posedge CLK or posedge RESET) begin
        for (int i = 0; i < 2; i++) begin
            mdone[i] = 0;
            merr[i]  = 0;
            if (RESET) begin
                mq[i].delete();
                act[i] = 0; seen[i] = 0; acc[i] = 0; movf[i] = 0; msum[i] = 0; mfsum[i] = 0;
            end else if (FRAME_START) begin
                merr[i] = act[i];
                mq[i].delete();
                act[i] = 1; seen[i] = 0; acc[i] = 0; movf[i] = 0; msum[i] = 0;
            end else begin
                if (mq[i].size() > 0 && PIX_READY) begin
                    void'(mq[i].pop_front());
                    if (act[i] != 0) acc[i]++;
                end
                if (act[i] != 0 && seen[i] < N && READ_STB) begin
                    if (mq[i].size() < dep[i]) begin
                        mq[i].push_back(enc(int'(DATA), seen[i] / COLS, seen[i] % COLS));
                        msum[i] += int'(DATA);
                    end else begin
                        movf[i] = 1;
                        acc[i]++;
                    end
                    seen[i]++;
                end
                if (act[i] != 0 && acc[i] == N) begin
                    mdone[i] = 1;
                    act[i]   = 0;
                    mfsum[i] = msum[i];
                end
            end
        end
    end

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d valid", i), int'(pv[i]), int'(mq[i].size() > 0));
            if (mq[i].size() > 0) chk($sformatf("u%0d head", i), head(i), mq[i][0]);
            chk($sformatf("u%0d overflow", i), int'(ov[i]), movf[i]);
            chk($sformatf("u%0d frame_done", i), int'(fd[i]), mdone[i]);
            chk($sformatf("u%0d frame_err", i), int'(fe[i]), merr[i]);
`ifdef PIXEL_RX_FRAME_SUM_EN
            chk($sformatf("u%0d frame_sum", i), int'(fs[i]), mfsum[i]);
`endif
        end
    end

    task automatic cyc(input logic fs_i, input logic stb, input logic [7:0] d, input logic rdy);
        FRAME_START = fs_i;
        READ_STB    = stb;
        DATA        = d;
        PIX_READY   = rdy;
        @(negedge CLK);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        chk("reset valid", int'(pv[0]), 0);
        chk("reset overflow", int'(ov[0]), 0);
        chk("reset done", int'(fd[0]), 0);

        cyc(1, 0, 0, 1);
        cyc(0, 1, 10, 1); chk("norm p0", head(0), enc(10, 0, 0));
        cyc(0, 1, 20, 1); chk("norm p1", head(0), enc(20, 0, 1));
        cyc(0, 1, 30, 1); chk("norm p2", head(0), enc(30, 1, 0));
        cyc(0, 1, 40, 1); chk("norm p3", head(0), enc(40, 1, 1));
        cyc(0, 0, 0, 1);  chk("norm done", int'(fd[0]), 1); chk("norm empty", int'(pv[0]), 0);
        chk("norm ovf", int'(ov[0]), 0);
`ifdef PIXEL_RX_FRAME_SUM_EN
        chk("norm sum", int'(fs[0]), 100);
`endif
        cyc(0, 0, 0, 1);  chk("norm done pulse", int'(fd[0]), 0);

        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0); chk("bp hold1", head(0), enc(1, 0, 0));
        cyc(0, 1, 2, 0); chk("bp hold2", head(0), enc(1, 0, 0)); chk("ovf before full", int'(ov[1]), 0);
        cyc(0, 1, 3, 0); chk("bp hold3", head(0), enc(1, 0, 0)); chk("ovf 3rd", int'(ov[1]), 1);
        cyc(0, 1, 4, 0); chk("bp hold4", head(0), enc(1, 0, 0)); chk("bp no ovf", int'(ov[0]), 0);
        cyc(0, 0, 0, 1); chk("bp pop2", head(0), enc(2, 0, 1)); chk("ovf pop2", head(1), enc(2, 0, 1));
        cyc(0, 0, 0, 1); chk("bp pop3", head(0), enc(3, 1, 0)); chk("ovf done", int'(fd[1]), 1);
        cyc(0, 0, 0, 1); chk("bp pop4", head(0), enc(4, 1, 1));
        cyc(0, 0, 0, 1); chk("bp done", int'(fd[0]), 1);
`ifdef PIXEL_RX_FRAME_SUM_EN
        chk("bp sum", int'(fs[0]), 10);
        chk("ovf sum", int'(fs[1]), 3);
`endif

        cyc(1, 0, 0, 0);
        cyc(0, 1, 5, 0);
        cyc(0, 1, 6, 0);
        cyc(1, 1, 99, 0); chk("restart err", int'(fe[0]), 1); chk("restart flushed", int'(pv[0]), 0);
        cyc(0, 1, 7, 1);  chk("restart err pulse", int'(fe[0]), 0); chk("restart t0", head(0), enc(7, 0, 0));
        cyc(0, 1, 8, 1);  chk("restart t1", head(0), enc(8, 0, 1));
        cyc(0, 1, 9, 1);  chk("restart t2", head(0), enc(9, 1, 0));
        cyc(0, 1, 11, 1); chk("restart t3", head(0), enc(11, 1, 1));
        cyc(0, 0, 0, 1);  chk("restart done", int'(fd[0]), 1);

        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 1, 3, 0); chk("pre-reset ovf", int'(ov[1]), 1);
        #2 RESET = 1'b1;
        #1;
        chk("async valid", int'(pv[0]), 0);
        chk("async ovf", int'(ov[1]), 0);
        chk("async done", int'(fd[0]), 0);
        @(negedge CLK);
        RESET = 1'b0;
        cyc(0, 1, 55, 1);
        cyc(0, 1, 56, 1); chk("idle ignores stb", int'(pv[0]), 0);

        cyc(1, 0, 0, 0);
        cyc(0, 1, 21, 0);
        cyc(0, 1, 22, 0);
        cyc(0, 1, 23, 1); chk("simul ovf", int'(ov[1]), 0); chk("simul head", head(1), enc(22, 0, 1));
        cyc(0, 0, 0, 1);  chk("simul kept", head(1), enc(23, 1, 0));

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                #2 RESET = 1'b1;
                @(negedge CLK);
                RESET = 1'b0;
            end else begin
                cyc($urandom_range(0, 14) == 0, $urandom_range(0, 1) == 1,
                    8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
